// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank
//  Purpose  : Bank of NUM_REGS registers, DATA_WIDTH bits each, on a
//             valid/ready request bus with a single-slot response.
//             Writes are byte-strobed. Registers selected by RO_MASK ignore
//             bus writes. Accesses to an out-of-range address return err.
//             Every register is also visible in parallel on regs_out.
//  Ports    : clk, rst                 - clock, asynchronous active-high reset
//             valid, ready             - request handshake
//             wr, addr, wdata, wstrb   - request payload
//             rsp_valid, rsp_ready     - response handshake
//             rdata, err               - response payload
//             regs_out                 - flattened register contents
//                                        (register i at [i*DATA_WIDTH +: DATA_WIDTH])
//  Revision : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter int                        DATA_WIDTH  = 32,
    parameter int                        NUM_REGS    = 8,
    parameter int                        ADDR_WIDTH  = 4,
    parameter logic [NUM_REGS-1:0]       RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid,
    output logic                           ready,
    input  logic                           wr,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int c_NBYTES = DATA_WIDTH / 8;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
        $error("reg_bank: DATA_WIDTH must be a non-zero multiple of 8");
    end

    if ((NUM_REGS < 1) || (NUM_REGS > (2 ** ADDR_WIDTH))) begin : g_bad_num_regs
        $error("reg_bank: NUM_REGS must be in 1..2**ADDR_WIDTH");
    end

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic [NUM_REGS-1:0]     w_addr_hit;
    logic                    w_in_range;
    logic                    w_ro_hit;
    logic [DATA_WIDTH-1:0]   w_rd_reg;
    logic [DATA_WIDTH-1:0]   w_regs [NUM_REGS];

    // The response slot is the only stall source: a new request can enter
    // whenever the slot is empty or is being drained on this same edge.
    assign ready    = !r_rsp_valid || rsp_ready;
    assign w_accept = valid && ready;

    // One-hot address decode. An address with no hit is out of range, which
    // avoids a width-sensitive compare against NUM_REGS when NUM_REGS equals
    // 2**ADDR_WIDTH.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_decode
        assign w_addr_hit[i] = (addr == ADDR_WIDTH'(i));
    end

    assign w_in_range = |w_addr_hit;

    // Read mux and read-only lookup. Both fall back to zero for an
    // out-of-range address so the response data is zero there for free.
    always_comb begin
        w_rd_reg = '0;
        w_ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr_hit[i]) begin
                w_rd_reg = w_regs[i];
                w_ro_hit = RO_MASK[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;
        logic                  w_we;

        // Read-only registers simply never see a write enable.
        assign w_we = w_accept && wr && w_addr_hit[i] && !RO_MASK[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= RESET_VALUE;
            end else if (w_we) begin
                for (int k = 0; k < c_NBYTES; k++) begin
                    if (wstrb[k]) begin
                        r_q[k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end
        end

        assign w_regs[i]                              = r_q;
        assign regs_out[i*DATA_WIDTH +: DATA_WIDTH]   = r_q;
    end

    // ------------------------------------------------------------------------
    // Response slot
    // ------------------------------------------------------------------------
    // Read data is sampled from the register outputs before the edge, so a
    // read sees the old value even if a write could land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rdata     <= wr ? '0 : w_rd_reg;
            r_err       <= !w_in_range || (wr && w_ro_hit);
        end else if (rsp_ready) begin
            // Drained with nothing new behind it; payload is left as-is.
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rdata     = r_rdata;
    assign err       = r_err;

endmodule
`default_nettype wire
